// File: rtl/pe_result_drain_pkg.sv
// Shared definitions for the PE array result path: accumulator width and type,
// plus the drain FSM state encoding.
package pe_result_drain_pkg;

    parameter int ACC_WIDTH = 32;

    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } drain_state_t;

endpackage

// File: rtl/pe_result_drain.sv
// Snapshots the PE array results on drain_start_i, pulses clear_acc_o, then streams
// one PE row per valid/ready beat so the next tile can compute during the drain.
//
//   state | meaning
//   IDLE  | waiting for drain_start_i; buffer holds the previous snapshot
//   SEND  | presenting snapshot row row_q; advances on each accepted beat
module pe_result_drain
    import pe_result_drain_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int ACC_WIDTH = pe_result_drain_pkg::ACC_WIDTH
) (
    input  logic                                 clk_i,
    input  logic                                 rst_async_n_i,
    input  logic [ROWS*COLS*ACC_WIDTH-1:0]       result_i,
    input  logic                                 drain_start_i,
    output logic                                 clear_acc_o,
    output logic                                 busy_o,
    output logic                                 dout_valid_o,
    input  logic                                 dout_ready_i,
    output logic [COLS*ACC_WIDTH-1:0]            dout_data_o,
    output logic [(ROWS > 1 ? $clog2(ROWS) : 1)-1:0] dout_row_o,
    output logic                                 dout_last_o
);

    localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int ROW_BITS = COLS * ACC_WIDTH;
    localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

    drain_state_t                   state_q;
    logic [RW-1:0]                  row_q;
    logic [ROWS*COLS*ACC_WIDTH-1:0] snap_q;
    logic                           clear_q;

    // drain_start_i is only honoured in IDLE, so a start during the last beat is dropped.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            state_q <= IDLE;
            row_q   <= '0;
            snap_q  <= '0;
            clear_q <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (drain_start_i) begin
                        snap_q  <= result_i;
                        row_q   <= '0;
                        clear_q <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (dout_ready_i) begin
                        if (row_q == LAST_ROW) begin
                            row_q   <= '0;
                            state_q <= IDLE;
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs decode registered state only; nothing combinational from the inputs.
    assign clear_acc_o  = clear_q;
    assign busy_o       = (state_q == SEND);
    assign dout_valid_o = (state_q == SEND);
    assign dout_row_o   = row_q;
    assign dout_last_o  = (state_q == SEND) && (row_q == LAST_ROW);
    assign dout_data_o  = snap_q[32'(row_q) * ROW_BITS +: ROW_BITS];

endmodule

// File: tb/tb_pe_result_drain.sv
// Directed bench for pe_result_drain: a 2x2 instance for the main drain scenarios
// and a 1x4 instance for the single-row case.
module tb_pe_result_drain;
    import pe_result_drain_pkg::*;

    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // 2x2 instance
    logic [4*AW-1:0] result;
    logic            start, ready;
    logic            clear_acc, busy, valid, last;
    logic [2*AW-1:0] data;
    logic [0:0]      row;

    // 1x4 instance
    logic [4*AW-1:0] result2;
    logic            start2, ready2;
    logic            clear_acc2, busy2, valid2, last2;
    logic [4*AW-1:0] data2;
    logic [0:0]      row2;

    pe_result_drain #(.ROWS(2), .COLS(2), .ACC_WIDTH(AW)) u_dut (
        .clk_i(clk), .rst_async_n_i(rst_n), .result_i(result),
        .drain_start_i(start), .clear_acc_o(clear_acc), .busy_o(busy),
        .dout_valid_o(valid), .dout_ready_i(ready), .dout_data_o(data),
        .dout_row_o(row), .dout_last_o(last)
    );

    pe_result_drain #(.ROWS(1), .COLS(4), .ACC_WIDTH(AW)) u_dut1 (
        .clk_i(clk), .rst_async_n_i(rst_n), .result_i(result2),
        .drain_start_i(start2), .clear_acc_o(clear_acc2), .busy_o(busy2),
        .dout_valid_o(valid2), .dout_ready_i(ready2), .dout_data_o(data2),
        .dout_row_o(row2), .dout_last_o(last2)
    );

    int errors = 0;
    int checks = 0;
    int beats  = 0;
    int clears = 0;

    always @(posedge clk) begin
        if (valid && ready) beats <= beats + 1;
        if (clear_acc) clears <= clears + 1;
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    acc_t pe00, pe01, pe10, pe11;
    logic [2*AW-1:0] b0, b1, n0, n1;
    logic [4*AW-1:0] orig;

    initial begin
        pe00 = 1; pe01 = -2; pe10 = 300; pe11 = -40000;
        orig = {pe11, pe10, pe01, pe00};
        b0 = 64'hFFFFFFFE_00000001;
        b1 = 64'hFFFF63C0_0000012C;
        n0 = {32'd20, 32'd10};
        n1 = {32'd40, 32'd30};
        result = orig; start = 1'b0; ready = 1'b1;
        result2 = {32'd8, 32'd7, 32'd6, 32'd5}; start2 = 1'b0; ready2 = 1'b1;

        // reset state
        #12;
        chk("rst_valid", 128'(valid), 128'd0);
        chk("rst_busy",  128'(busy),  128'd0);
        chk("rst_clear", 128'(clear_acc), 128'd0);
        chk("rst_data",  128'(data),  128'd0);
        chk("rst_row",   128'(row),   128'd0);
        chk("rst_last",  128'(last),  128'd0);
        @(negedge clk); rst_n = 1'b1;
        cyc(); cyc();
        chk("idle_valid", 128'(valid), 128'd0);

        // basic drain, ready high
        start = 1'b1; cyc(); start = 1'b0;
        chk("t1_clear", 128'(clear_acc), 128'd1);
        chk("t1_valid0", 128'(valid), 128'd1);
        chk("t1_busy0", 128'(busy), 128'd1);
        chk("t1_row0", 128'(row), 128'd0);
        chk("t1_last0", 128'(last), 128'd0);
        chk("t1_data0", 128'(data), 128'(b0));
        cyc();
        chk("t1_clear_off", 128'(clear_acc), 128'd0);
        chk("t1_valid1", 128'(valid), 128'd1);
        chk("t1_row1", 128'(row), 128'd1);
        chk("t1_last1", 128'(last), 128'd1);
        chk("t1_data1", 128'(data), 128'(b1));
        cyc();
        chk("t1_valid_end", 128'(valid), 128'd0);
        chk("t1_busy_end", 128'(busy), 128'd0);
        chk("t1_last_end", 128'(last), 128'd0);

        // backpressure: ready low for 5 cycles
        ready = 1'b0;
        start = 1'b1; cyc(); start = 1'b0;
        beats = 0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 128'(valid), 128'd1);
            chk("bp_row", 128'(row), 128'd0);
            chk("bp_data", 128'(data), 128'(b0));
            if (i < 4) cyc();
        end
        ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (!busy) break;
        end
        chk("bp_idle", 128'(busy), 128'd0);
        chk("bp_beats", 128'(beats), 128'd2);

        // snapshot independence
        start = 1'b1; cyc(); start = 1'b0;
        result = {4{32'h7FFFFFFF}};
        chk("snap_data0", 128'(data), 128'(b0));
        cyc();
        chk("snap_data1", 128'(data), 128'(b1));
        cyc();
        result = orig;

        // start pulses while busy, including the last-handshake cycle
        beats = 0; clears = 0;
        start = 1'b1; cyc(); cyc(); cyc(); start = 1'b0;
        chk("ign_busy", 128'(busy), 128'd0);
        chk("ign_clear", 128'(clear_acc), 128'd0);
        cyc();
        chk("ign_busy2", 128'(busy), 128'd0);
        chk("ign_clears", 128'(clears), 128'd1);
        chk("ign_beats", 128'(beats), 128'd2);
        result = {32'd40, 32'd30, 32'd20, 32'd10};
        start = 1'b1; cyc(); start = 1'b0;
        chk("fresh_data0", 128'(data), 128'(n0));
        cyc();
        chk("fresh_data1", 128'(data), 128'(n1));
        cyc();
        result = orig;

        // asynchronous reset mid-drain
        start = 1'b1; cyc(); start = 1'b0;
        cyc();
        chk("ar_row1", 128'(row), 128'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 128'(valid), 128'd0);
        chk("ar_busy", 128'(busy), 128'd0);
        chk("ar_clear", 128'(clear_acc), 128'd0);
        @(negedge clk); rst_n = 1'b1;
        cyc();
        start = 1'b1; cyc(); start = 1'b0;
        chk("ar_post_row0", 128'(row), 128'd0);
        chk("ar_post_data0", 128'(data), 128'(b0));
        cyc();
        chk("ar_post_data1", 128'(data), 128'(b1));
        cyc();
        chk("ar_post_idle", 128'(busy), 128'd0);

        // single-row instance
        start2 = 1'b1; cyc(); start2 = 1'b0;
        chk("r1_valid", 128'(valid2), 128'd1);
        chk("r1_last", 128'(last2), 128'd1);
        chk("r1_row", 128'(row2), 128'd0);
        chk("r1_data", data2, {32'd8, 32'd7, 32'd6, 32'd5});
        chk("r1_clear", 128'(clear_acc2), 128'd1);
        cyc();
        chk("r1_valid_end", 128'(valid2), 128'd0);
        chk("r1_busy_end", 128'(busy2), 128'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
